imm_extend_pipe: RTL
====================

IMM_EXTEND_PIPE -- requirements
Module: Imm_Extend_Pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, immediate input width (>=1).
REQ-002 The block SHALL have parameter OUT_W, default 32, extended output width (>=IN_W).
REQ-003 The block SHALL have parameter DEPTH, default 2, output buffer entries (power of 2, >=2).
REQ-004 The block SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port valid_i, input, 1, upstream item present.
REQ-007 The block SHALL have port ready_o, output, 1, block can accept an item.
REQ-008 The block SHALL have port data_i, input, IN_W, immediate field.
REQ-009 The block SHALL have port mode_i, input, 2, extension mode: 00 sign, 01 zero, 10 upper, 11 reserved.
REQ-010 The block SHALL have port valid_o, output, 1, buffer head holds a result.
REQ-011 The block SHALL have port ready_i, input, 1, downstream accepts the head.
REQ-012 The block SHALL have port data_o, output, OUT_W, extended result at buffer head.
REQ-013 The block SHALL have port err_o, output, 1, sticky reserved-mode flag.
REQ-014 The block SHALL have port count_o, output, 16, completed output transfers, wraps modulo 2^16.

Function
REQ-015 The block SHALL push when valid_i && ready_o at a rising edge, and pop when valid_o && ready_i at a rising edge.
REQ-016 Mode 00 SHALL produce {(OUT_W-IN_W){data_i[IN_W-1]}, data_i}; mode 01 SHALL produce {(OUT_W-IN_W){0}, data_i}.
REQ-017 Mode 10 SHALL produce data_i placed in bits [OUT_W-1:OUT_W-IN_W] with lower bits zero (LUI-style).
REQ-018 When OUT_W == IN_W, modes 00, 01 and 10 SHALL all pass data_i unchanged.
REQ-019 Mode 11 SHALL push a result of all zeros and set err_o to 1 on the accepting edge.
REQ-020 Extension SHALL be computed on data_i/mode_i at the accepting edge; later changes to them SHALL not affect stored entries.
REQ-021 Latency SHALL be one cycle: an item accepted at edge N SHALL drive valid_o=1 and data_o from edge N onward when the buffer was empty.
REQ-022 Items SHALL leave in acceptance order (FIFO); data_o SHALL show the oldest entry; data_o SHALL be all zeros while empty.
REQ-023 ready_o SHALL be 1 iff occupancy < DEPTH and SHALL be a registered-state function with no combinational path from ready_i or valid_i.
REQ-024 When full, a push attempt SHALL be ignored even if a pop occurs on the same edge; valid_i held high is accepted on the next edge.
REQ-025 When neither full nor empty, simultaneous push and pop SHALL leave occupancy unchanged.
REQ-026 A pop on an empty buffer SHALL not occur; valid_o=0 and ready_i SHALL have no effect.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-028 count_o SHALL increment by 1 per pop and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-029 err_o SHALL remain 1 until reset; further mode 11 items SHALL not change it.

Reset
REQ-030 Assertion of rst_i low SHALL immediately, without a clock, force: valid_o=0, data_o=0, err_o=0, count_o=0, occupancy=0, and pointers to 0.
REQ-031 ready_o SHALL be 0 while rst_i is low and 1 from the first state after release.
REQ-032 Reset mid-operation SHALL discard all buffered entries; no item accepted before reset SHALL appear after it.

Verification
REQ-033 The bench SHALL drive mode 00 with data_i=16'h8001, then 16'h7FFF -> data_o=32'hFFFF8001, then 32'h00007FFF, each one cycle after acceptance.
REQ-034 The bench SHALL drive mode 01 with 16'h8001 and mode 10 with 16'h1234 -> 32'h00008001 and 32'h12340000; mode 11 with 16'hFFFF -> data_o=0, err_o=1, err_o still 1 after 5 more mode-00 items.
REQ-035 The bench SHALL hold ready_i=0 and valid_i=1 -> exactly 2 accepted, ready_o=0; then assert ready_i=1 -> outputs drain in order and ready_o rises the edge after the first pop.
REQ-036 The bench SHALL run random valid_i/ready_i for 70000 transfers against a reference queue -> zero mismatches, and count_o = 70000 mod 65536 = 4464.
REQ-037 The bench SHALL assert rst_i low between clock edges with 2 entries buffered -> outputs clear immediately and no stale item appears after release.
REQ-038 The bench SHALL run with IN_W=8, OUT_W=8, DEPTH=4 and modes 00 and 10 on 8'hA5 -> 8'hA5 for both, with 4-deep full behaviour.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Immediate extension stage with an output FIFO.
// Sign, zero or upper (LUI-style) extension with a sticky reserved-mode flag.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             err_o,
  output logic [15:0]      count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SH = OUT_W - IN_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      occ_nxt;
  logic             ready_q;
  logic             push;
  logic             pop;
  logic             rsvd;
  logic [OUT_W-1:0] ext;
  logic signed [IN_W-1:0] d_s;

  assign d_s     = data_i;
  assign push    = valid_i & ready_q;
  assign pop     = valid_o & ready_i;
  assign rsvd    = (mode_i == 2'b11);
  assign ready_o = ready_q;
  assign valid_o = (occ != '0);
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

  // Extension of the incoming immediate; reserved mode yields zero.
  always_comb begin
    ext = '0;
    unique case (mode_i)
      2'b00: ext = OUT_W'(d_s);
      2'b01: ext = OUT_W'(data_i);
      2'b10: ext = OUT_W'(data_i) << SH;
      2'b11: ext = '0;
    endcase
  end

  // Occupancy after this edge's push and pop.
  always_comb begin
    occ_nxt = occ;
    unique case (1'b1)
      push & ~pop: occ_nxt = occ + (AW+1)'(1);
      pop & ~push: occ_nxt = occ - (AW+1)'(1);
      default:     occ_nxt = occ;
    endcase
  end

  // Pointers, occupancy, registered ready, error flag and transfer count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      ready_q <= 1'b0;
      err_o   <= 1'b0;
      count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ     <= occ_nxt;
      ready_q <= (occ_nxt < FULL);
      if (push && rsvd) err_o <= 1'b1;
      if (pop) count_o <= count_o + 16'd1;
    end
  end

  // Entry storage; stale contents are masked by occupancy.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= ext;
  end

endmodule
